santacrc_tamagotchi: RTL and testbench
======================================

# santacrc_tamagotchi

Virtual-pet game core for a Tiny Tapeout tile: it tracks hunger, happiness and energy for one pet, decays them on a periodic game tick, and reacts to four player buttons. It is the top-level user design behind the standard tile pin interface. `uo_out` drives the pet-state display and `uio_out` drives the 8-bit status bus.

## Interface
- TICK_DIV, 1000: clock cycles per game tick; must be ≥ 2.
- ACT_CYCLES, 4: number of cycles spent in EATING or PLAYING before returning to IDLE.
- SICK_LIMIT, 8: consecutive ticks spent SICK before the pet dies.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; synchronous and active-high (asserted = 1, despite the suffix).
- ena  in  1  tile select; ignored, the design runs whenever clocked.
- ui_in  in  8  [0] feed, [1] play, [2] sleep/wake, [3] medicine; [7:4] ignored.
- uio_in  in  8  ignored.
- uo_out  out  8  {energy[3:0], alive, state[2:0]}.
- uio_out  out  8  status = {happiness[3:0], hunger[3:0]}.
- uio_oe  out  8  constant 8'hFF.

## Operation
- Stats are 4-bit unsigned: hunger (15 = starving), happiness, energy. All updates saturate to 0..15.
- State codes: IDLE=0, EATING=1, PLAYING=2, SLEEPING=3, SICK=4, DEAD=5.
- Reset values: hunger 0, happiness 15, energy 15, state IDLE, tick counter 0, sick count 0, button history 0.
  - uo_out = 8'hF8, uio_out = 8'hF0.
- Button press = rising edge: ui_in[i]=1 while the registered previous ui_in[i]=0.
  - If several presses occur in one cycle, only the highest priority is acted on: feed > play > sleep > medicine.
- Tick: a counter runs 0..TICK_DIV-1 and pulses on its terminal count. It keeps running in every state except DEAD.
- Tick effects by state:
  - IDLE, EATING, PLAYING: hunger +1, happiness −1, energy −1.
  - SLEEPING: hunger +1, energy +2.
  - SICK: hunger +1, happiness −1, sick count +1.
- Actions:
  - Feed (IDLE or SICK): hunger −4. From IDLE, go to EATING; a SICK pet stays SICK.
  - Play (IDLE only, requires energy ≥ 2): happiness +3, energy −2, hunger +1, go to PLAYING. With energy < 2 the press is ignored.
  - Sleep (IDLE): go to SLEEPING. Sleep (SLEEPING): go to IDLE.
  - Medicine (SICK): go to IDLE, sick count cleared, happiness +2.
- Presses not listed for the current state are ignored. All presses are ignored in EATING, PLAYING and DEAD.
- EATING and PLAYING return to IDLE after exactly ACT_CYCLES cycles.
- SLEEPING auto-wakes to IDLE on the cycle energy becomes 15.
- Sickness: on a tick where the state is IDLE and the post-update hunger is 15 or happiness is 0, go to SICK and clear the sick count.
- Death: when sick count reaches SICK_LIMIT, go to DEAD.
  - DEAD freezes all stats, sets alive = 0, and ignores every input until reset.
- Same-cycle action and tick: deltas from both are summed on the old values and saturated once. The action's state transition wins over tick-driven transitions.

## Timing
- All outputs are registered. A press changes uo_out/uio_out on the clock edge after the cycle in which the edge is detected, giving 1-cycle latency from the sampled input to the output.
- The first tick occurs on the TICK_DIV-th clock edge after reset release.
- An action state entered at edge N returns to IDLE at edge N+ACT_CYCLES.
- Reset asserted mid-operation restores all reset values on the next edge, regardless of state, including DEAD.

## Test plan
- Reset (TICK_DIV=1000) -> uo_out=8'hF8, uio_out=8'hF0, uio_oe=8'hFF.
- TICK_DIV=10, no input, 3 ticks -> hunger 3, happiness 12, energy 12, state IDLE; status=8'hC3.
- From hunger 3 press feed -> hunger 0, state EATING (uo_out[2:0]=1) for 4 cycles, then IDLE. Holding feed high does not re-trigger.
- Energy 1, press play -> ignored. Press sleep -> SLEEPING; energy rises +2 per tick; auto-wake at 15.
- TICK_DIV=2, idle until hunger 15 -> SICK; 8 further ticks -> DEAD, alive=0, outputs frozen; press every button -> no change; assert rst_n=1 -> reset values.
- Feed and play pressed in the same cycle -> only feed applied. A press landing on a tick cycle -> combined saturated result.

Source files
------------

// File: rtl/santacrc_tamagotchi.sv
// Virtual-pet core: hunger/happiness/energy decayed by a game tick and driven by four edge-detected buttons.
// Latency 1 cycle from a sampled button edge or tick to the registered outputs; no backpressure, DEAD ignores input until reset.
module santacrc_tamagotchi #(
    parameter int TICK_DIV   = 1000,
    parameter int ACT_CYCLES = 4,
    parameter int SICK_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int TCW = $clog2(TICK_DIV);
    localparam int ACW = $clog2(ACT_CYCLES + 1);
    localparam int SCW = $clog2(SICK_LIMIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EATING   = 3'd1,
        ST_PLAYING  = 3'd2,
        ST_SLEEPING = 3'd3,
        ST_SICK     = 3'd4,
        ST_DEAD     = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       hunger;
    logic [3:0]       happiness;
    logic [3:0]       energy;
    logic [3:0]       hun_nxt;
    logic [3:0]       hap_nxt;
    logic [3:0]       eng_nxt;
    logic [TCW-1:0]   tick_cnt;
    logic [TCW-1:0]   tick_nxt;
    logic [SCW-1:0]   sick_cnt;
    logic [SCW-1:0]   sick_nxt;
    logic [ACW-1:0]   act_cnt;
    logic [ACW-1:0]   act_nxt;
    logic [3:0]       btn_prev;
    logic [3:0]       press;
    logic             tick;
    logic             acted;
    logic [4:0]       d_hun;
    logic [4:0]       d_hap;
    logic [4:0]       d_eng;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4]};

    // Deltas are 5-bit two's complement; result is clamped once to 0..15.
    function automatic logic [3:0] sat4(input logic [3:0] v, input logic [4:0] d);
        logic [6:0] s;
        s = {3'b000, v} + {{2{d[4]}}, d};
        if (s[6])
            sat4 = 4'd0;
        else if (|s[5:4])
            sat4 = 4'd15;
        else
            sat4 = s[3:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state     <= ST_IDLE;
            hunger    <= 4'd0;
            happiness <= 4'd15;
            energy    <= 4'd15;
            tick_cnt  <= '0;
            sick_cnt  <= '0;
            act_cnt   <= '0;
            btn_prev  <= 4'd0;
        end else begin
            state     <= state_nxt;
            hunger    <= hun_nxt;
            happiness <= hap_nxt;
            energy    <= eng_nxt;
            tick_cnt  <= tick_nxt;
            sick_cnt  <= sick_nxt;
            act_cnt   <= act_nxt;
            btn_prev  <= ui_in[3:0];
        end
    end

    always_comb begin
        press     = ui_in[3:0] & ~btn_prev;
        tick      = (state != ST_DEAD) && (tick_cnt == TCW'(TICK_DIV - 1));
        state_nxt = state;
        tick_nxt  = tick_cnt;
        sick_nxt  = sick_cnt;
        act_nxt   = act_cnt;
        d_hun     = 5'd0;
        d_hap     = 5'd0;
        d_eng     = 5'd0;
        acted     = 1'b0;

        if (state != ST_DEAD)
            tick_nxt = tick ? '0 : tick_cnt + TCW'(1);

        if (tick) begin
            d_hun = 5'd1;
            case (state)
                ST_SLEEPING: d_eng = 5'd2;
                ST_SICK: begin
                    d_hap    = 5'h1F;
                    sick_nxt = sick_cnt + SCW'(1);
                end
                default: begin
                    d_hap = 5'h1F;
                    d_eng = 5'h1F;
                end
            endcase
        end

        // Only the highest-priority press is considered, even if this state ignores it.
        if (press[0]) begin
            if (state == ST_IDLE) begin
                d_hun     = d_hun - 5'd4;
                state_nxt = ST_EATING;
                act_nxt   = '0;
                acted     = 1'b1;
            end else if (state == ST_SICK) begin
                d_hun = d_hun - 5'd4;
            end
        end else if (press[1]) begin
            if (state == ST_IDLE && energy >= 4'd2) begin
                d_hap     = d_hap + 5'd3;
                d_eng     = d_eng - 5'd2;
                d_hun     = d_hun + 5'd1;
                state_nxt = ST_PLAYING;
                act_nxt   = '0;
                acted     = 1'b1;
            end
        end else if (press[2]) begin
            if (state == ST_IDLE) begin
                state_nxt = ST_SLEEPING;
                acted     = 1'b1;
            end else if (state == ST_SLEEPING) begin
                state_nxt = ST_IDLE;
                acted     = 1'b1;
            end
        end else if (press[3]) begin
            if (state == ST_SICK) begin
                d_hap     = d_hap + 5'd2;
                sick_nxt  = '0;
                state_nxt = ST_IDLE;
                acted     = 1'b1;
            end
        end

        hun_nxt = sat4(hunger, d_hun);
        hap_nxt = sat4(happiness, d_hap);
        eng_nxt = sat4(energy, d_eng);

        // Tick/timer-driven transitions only apply when no action moved the state.
        if (!acted) begin
            case (state)
                ST_IDLE: begin
                    if (tick && (hun_nxt == 4'd15 || hap_nxt == 4'd0)) begin
                        state_nxt = ST_SICK;
                        sick_nxt  = '0;
                    end
                end
                ST_EATING, ST_PLAYING: begin
                    if (act_cnt == ACW'(ACT_CYCLES - 1))
                        state_nxt = ST_IDLE;
                    else
                        act_nxt = act_cnt + ACW'(1);
                end
                ST_SLEEPING: begin
                    if (eng_nxt == 4'd15)
                        state_nxt = ST_IDLE;
                end
                ST_SICK: begin
                    if (sick_nxt == SCW'(SICK_LIMIT))
                        state_nxt = ST_DEAD;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        uo_out  = {energy, state != ST_DEAD, state};
        uio_out = {happiness, hunger};
        uio_oe  = 8'hFF;
    end
endmodule

// File: tb/tb_santacrc_tamagotchi.sv
// Three pets with different tick rates share one stimulus stream; a reference model
// predicts each pet's outputs and a monitor compares them every cycle.
module tb_santacrc_tamagotchi;
    localparam int ACT  = 4;
    localparam int SLIM = 8;
    localparam int IDLE = 0, EATING = 1, PLAYING = 2, SLEEPING = 3, SICK = 4, DEAD = 5;

    typedef struct {
        int         hun;
        int         hap;
        int         eng;
        int         st;
        int         tcnt;
        int         scnt;
        int         act_left;
        logic [3:0] prev;
    } pet_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_s, uio_s, oe_s;
    logic [7:0] uo_m, uio_m, oe_m;
    logic [7:0] uo_f, uio_f, oe_f;

    int n_checks = 0;
    int n_errors = 0;

    pet_t        mdl [3];
    int          divs [3] = '{1000, 10, 2};
    logic [15:0] q_slow [$];
    logic [15:0] q_mid  [$];
    logic [15:0] q_fast [$];

    always #5 clk = ~clk;

    santacrc_tamagotchi #(.TICK_DIV(1000), .ACT_CYCLES(ACT), .SICK_LIMIT(SLIM)) u_slow (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_s), .uio_out(uio_s), .uio_oe(oe_s));
    santacrc_tamagotchi #(.TICK_DIV(10), .ACT_CYCLES(ACT), .SICK_LIMIT(SLIM)) u_mid (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_m), .uio_out(uio_m), .uio_oe(oe_m));
    santacrc_tamagotchi #(.TICK_DIV(2), .ACT_CYCLES(ACT), .SICK_LIMIT(SLIM)) u_fast (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_f), .uio_out(uio_f), .uio_oe(oe_f));

    function automatic int clamp(int v);
        return (v < 0) ? 0 : ((v > 15) ? 15 : v);
    endfunction

    function automatic logic [15:0] pack(pet_t m);
        return {4'(m.eng), (m.st != DEAD), 3'(m.st), 4'(m.hap), 4'(m.hun)};
    endfunction

    function automatic pet_t model_step(pet_t p, bit rst, logic [7:0] ui, int div);
        pet_t n;
        int   dh, dy, de, pick;
        bit   tick, acted;
        n = p;
        if (rst) begin
            n.hun = 0; n.hap = 15; n.eng = 15; n.st = IDLE;
            n.tcnt = 0; n.scnt = 0; n.act_left = 0; n.prev = 4'h0;
            return n;
        end
        n.prev = ui[3:0];
        if (p.st == DEAD) return n;
        tick   = (p.tcnt == div - 1);
        n.tcnt = tick ? 0 : p.tcnt + 1;
        dh = 0; dy = 0; de = 0; acted = 0;
        if (tick) begin
            dh = 1;
            if (p.st == SLEEPING) de = 2;
            else if (p.st == SICK) begin dy = -1; n.scnt = p.scnt + 1; end
            else begin dy = -1; de = -1; end
        end
        pick = -1;
        for (int i = 3; i >= 0; i--)
            if (ui[i] && !p.prev[i]) pick = i;
        case (pick)
            0: if (p.st == IDLE) begin
                   dh -= 4; n.st = EATING; n.act_left = ACT; acted = 1;
               end else if (p.st == SICK) dh -= 4;
            1: if (p.st == IDLE && p.eng >= 2) begin
                   dy += 3; de -= 2; dh += 1; n.st = PLAYING; n.act_left = ACT; acted = 1;
               end
            2: if (p.st == IDLE) begin n.st = SLEEPING; acted = 1; end
               else if (p.st == SLEEPING) begin n.st = IDLE; acted = 1; end
            3: if (p.st == SICK) begin n.st = IDLE; n.scnt = 0; dy += 2; acted = 1; end
            default: ;
        endcase
        n.hun = clamp(p.hun + dh);
        n.hap = clamp(p.hap + dy);
        n.eng = clamp(p.eng + de);
        if (!acted) begin
            if (p.st == EATING || p.st == PLAYING) begin
                n.act_left = p.act_left - 1;
                if (n.act_left == 0) n.st = IDLE;
            end else if (p.st == IDLE && tick && (n.hun == 15 || n.hap == 0)) begin
                n.st = SICK; n.scnt = 0;
            end else if (p.st == SLEEPING && n.eng == 15) begin
                n.st = IDLE;
            end else if (p.st == SICK && n.scnt >= SLIM) begin
                n.st = DEAD;
            end
        end
        return n;
    endfunction

    // Inputs change on the falling edge; the expectation for the next rising edge is queued now.
    task automatic drive(input bit r, input logic [7:0] u);
        rst_n  = r;
        ui_in  = u;
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
        for (int k = 0; k < 3; k++) mdl[k] = model_step(mdl[k], r, u, divs[k]);
        q_slow.push_back(pack(mdl[0]));
        q_mid.push_back(pack(mdl[1]));
        q_fast.push_back(pack(mdl[2]));
        @(negedge clk);
    endtask

    task automatic check_out(input string name, input logic [15:0] got, input logic [15:0] exp,
                             input logic [7:0] oe);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: uo_out=%h uio_out=%h, expected uo_out=%h uio_out=%h",
                     name, $time, got[15:8], got[7:0], exp[15:8], exp[7:0]);
        end
        n_checks++;
        if (oe !== 8'hFF) begin
            n_errors++;
            $display("FAIL %s_oe @%0t: uio_oe=%h, expected ff", name, $time, oe);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_slow.size() > 0) check_out("div1000", {uo_s, uio_s}, q_slow.pop_front(), oe_s);
            if (q_mid.size() > 0)  check_out("div10",   {uo_m, uio_m}, q_mid.pop_front(),  oe_m);
            if (q_fast.size() > 0) check_out("div2",    {uo_f, uio_f}, q_fast.pop_front(), oe_f);
        end
    end

    initial begin
        logic [7:0] u;
        int         hold;
        for (int k = 0; k < 3; k++) begin
            mdl[k].hun = 0; mdl[k].hap = 0; mdl[k].eng = 0; mdl[k].st = 0;
            mdl[k].tcnt = 0; mdl[k].scnt = 0; mdl[k].act_left = 0; mdl[k].prev = 4'h0;
        end

        repeat (3) drive(1, 8'h00);
        repeat (30) drive(0, 8'h00);
        repeat (8) drive(0, 8'h01);
        repeat (6) drive(0, 8'h00);

        // Drain energy to 1 on the div-10 pet, then try play and sleep.
        drive(1, 8'h00);
        repeat (140) drive(0, 8'h00);
        drive(0, 8'h02); drive(0, 8'h00);
        drive(0, 8'h04); drive(0, 8'h00);
        repeat (90) drive(0, 8'h00);

        // Starve the div-2 pet to death, then poke every button before reviving it.
        drive(1, 8'h00);
        repeat (60) drive(0, 8'h00);
        for (int b = 0; b < 4; b++) begin
            drive(0, 8'h01 << b);
            drive(0, 8'h00);
        end
        drive(0, 8'hFF); drive(0, 8'h00);
        drive(1, 8'h00);
        repeat (3) drive(0, 8'h00);

        // Simultaneous feed+play, and presses landing on the div-10 tick edge.
        drive(1, 8'h00);
        drive(0, 8'h03);
        repeat (8) drive(0, 8'h00);
        drive(1, 8'h00);
        repeat (9) drive(0, 8'h00);
        drive(0, 8'h01);
        repeat (12) drive(0, 8'h00);
        drive(1, 8'h00);
        repeat (9) drive(0, 8'h00);
        drive(0, 8'h02);
        repeat (12) drive(0, 8'h00);

        // Random single-button play with hold times and rare resets.
        drive(1, 8'h00);
        for (int c = 0; c < 3000; c += hold) begin
            if ($urandom_range(0, 5) < 4) u = 8'h01 << $urandom_range(0, 3);
            else u = 8'h00;
            u[7:4] = 4'($urandom);
            hold = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) drive($urandom_range(0, 399) == 0, u);
        end
        drive(0, 8'h00);

        @(posedge clk);
        #3;
        n_checks++;
        if (q_slow.size() + q_mid.size() + q_fast.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0",
                     q_slow.size() + q_mid.size() + q_fast.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
